// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcode constants, fetch FSM state encoding and default datapath width
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} fetchState_e;
endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational sign-extended immediate for I (load/op-imm), S and B formats; 0 otherwise
//   instr : instruction word (XLEN)   imm : sign-extended immediate (XLEN)
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imm
);
  logic [6:0] op;
  assign op = instr[6:0];
  always_comb
    imm = (op == OP_LOAD || op == OP_IMM) ? {{(XLEN-12){instr[31]}}, instr[31:20]} :
          (op == OP_STORE)  ? {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]} :
          (op == OP_BRANCH) ? {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
          '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with instruction register, stall/branch redirect and field decode
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   imem_req/addr/ack/rdata: instruction memory handshake (address = fetch_pc while requesting)
//   stall, branch_taken, branch_offset : downstream hold and pc-relative redirect of the held instruction
//   instr_valid, instr, pc : held instruction and its address
//   opcode..funct7, imm    : fields and immediate decoded from the held instruction
//   err                    : misaligned redirect (only when built with PC_ALIGN_CHECK_EN, else tied 0)
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_offset,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic            err
);
  fetchState_e state;
  logic [XLEN-1:0] fetchPc;
  logic [XLEN-1:0] target;
  assign target = branch_taken ? pc + branch_offset : pc + XLEN'(4);
  assign imem_addr = fetchPc;
  assign opcode = instr[6:0];
  assign rd = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign funct7 = instr[31:25];
  imm_gen #(.XLEN(XLEN)) immGen (.instr(instr), .imm(imm));
`ifndef PC_ALIGN_CHECK_EN
  assign err = 1'b0;
`endif
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      fetchPc <= RESET_PC;
      pc <= '0;
      instr <= '0;
      imem_req <= 1'b0;
      instr_valid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      err <= 1'b0;
`endif
    end else
      case (state)
        IDLE: begin
          state <= REQ;
          imem_req <= 1'b1;
        end
        REQ:
          if (imem_ack) begin
            instr <= imem_rdata;
            pc <= fetchPc;
            state <= VALID;
            imem_req <= 1'b0;
            instr_valid <= 1'b1;
          end
        VALID:
          if (!stall) begin
            instr_valid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            if (target[1:0] != 2'b00) begin
              state <= ERR;
              err <= 1'b1;
            end else
`endif
            begin
              fetchPc <= target & ~XLEN'(3);
              state <= REQ;
              imem_req <= 1'b1;
            end
          end
        default: ;
      endcase
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = '0;
  logic        instr_valid;
  logic [31:0] instr, pc, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        err;
  int nCmp = 0;
  int nBad = 0;

  localparam logic [31:0] LB_WORD  = 32'h0030_0083;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [31:0] BNE_WORD = 32'hFE20_9CE3;
  localparam logic [31:0] SB_WORD  = 32'hFE20_8FA3;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .err(err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    nCmp++; if (imem_req !== 1'b0) begin nBad++; $display("FAIL rst_req got %0b want 0", imem_req); end
    nCmp++; if (instr_valid !== 1'b0) begin nBad++; $display("FAIL rst_valid got %0b want 0", instr_valid); end
    nCmp++; if (err !== 1'b0) begin nBad++; $display("FAIL rst_err got %0b want 0", err); end
    nCmp++; if (pc !== 32'h0 || instr !== 32'h0) begin nBad++; $display("FAIL rst_regs got pc=%h instr=%h want 0/0", pc, instr); end
    reset = 1'b0;
    step();
    nCmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin nBad++; $display("FAIL first_req got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
    step();
    nCmp++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin nBad++; $display("FAIL wait_ack got req=%0b valid=%0b want 1/0", imem_req, instr_valid); end
    imem_ack = 1'b1;
    imem_rdata = LB_WORD;
    step();
    imem_ack = 1'b0;
    nCmp++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin nBad++; $display("FAIL lb_valid got valid=%0b req=%0b want 1/0", instr_valid, imem_req); end
    nCmp++; if (opcode !== 7'b0000011 || rd !== 5'd1 || rs1 !== 5'd0 || funct3 !== 3'd0) begin nBad++; $display("FAIL lb_fields got op=%b rd=%0d rs1=%0d f3=%0d want 0000011/1/0/0", opcode, rd, rs1, funct3); end
    nCmp++; if (imm !== 32'd3 || pc !== 32'h0) begin nBad++; $display("FAIL lb_imm got imm=%h pc=%h want 3/0", imm, pc); end
  endtask

  task automatic test_sequential();
    step();
    nCmp++; if (imem_addr !== 32'h4 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin nBad++; $display("FAIL seq_addr4 got addr=%h req=%0b valid=%0b want 4/1/0", imem_addr, imem_req, instr_valid); end
    imem_ack = 1'b1;
    imem_rdata = NOP_WORD;
    step();
    imem_ack = 1'b0;
    nCmp++; if (pc !== 32'h4 || instr !== NOP_WORD || imm !== 32'h0) begin nBad++; $display("FAIL seq_pc4 got pc=%h instr=%h imm=%h want 4/%h/0", pc, instr, imm, NOP_WORD); end
    step();
    nCmp++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin nBad++; $display("FAIL seq_addr8 got addr=%h req=%0b want 8/1", imem_addr, imem_req); end
    imem_ack = 1'b1;
    imem_rdata = BNE_WORD;
    step();
    imem_ack = 1'b0;
    nCmp++; if (pc !== 32'h8 || opcode !== 7'b1100011 || imm !== 32'hFFFF_FFF8) begin nBad++; $display("FAIL bne_hold got pc=%h op=%b imm=%h want 8/1100011/fffffff8", pc, opcode, imm); end
    nCmp++; if (rs1 !== 5'd1 || rs2 !== 5'd2 || funct3 !== 3'd1) begin nBad++; $display("FAIL bne_fields got rs1=%0d rs2=%0d f3=%0d want 1/2/1", rs1, rs2, funct3); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_offset = 32'hFFFF_FFF8;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      nCmp++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h8 || instr !== BNE_WORD || imem_addr !== 32'h8) begin
        nBad++; $display("FAIL stall_hold%0d got valid=%0b req=%0b pc=%h instr=%h addr=%h want 1/0/8/%h/8", i, instr_valid, imem_req, pc, instr, imem_addr, BNE_WORD);
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_branch();
    stall = 1'b0;
    step();
    branch_taken = 1'b0;
    nCmp++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin nBad++; $display("FAIL br_target got addr=%h req=%0b valid=%0b want 0/1/0", imem_addr, imem_req, instr_valid); end
    imem_ack = 1'b1;
    imem_rdata = SB_WORD;
    step();
    imem_ack = 1'b0;
    nCmp++; if (imm !== 32'hFFFF_FFFF || opcode !== 7'b0100011 || pc !== 32'h0) begin nBad++; $display("FAIL sb_imm got imm=%h op=%b pc=%h want ffffffff/0100011/0", imm, opcode, pc); end
    nCmp++; if (funct7 !== 7'h7F || rs2 !== 5'd2 || rs1 !== 5'd1) begin nBad++; $display("FAIL sb_fields got f7=%h rs2=%0d rs1=%0d want 7f/2/1", funct7, rs2, rs1); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1;
    branch_offset = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    nCmp++; if (imem_addr !== 32'hFFFF_FFFC) begin nBad++; $display("FAIL wrap_neg got addr=%h want fffffffc", imem_addr); end
    imem_ack = 1'b1;
    imem_rdata = NOP_WORD;
    step();
    imem_ack = 1'b0;
    nCmp++; if (pc !== 32'hFFFF_FFFC) begin nBad++; $display("FAIL wrap_pc got pc=%h want fffffffc", pc); end
    step();
    nCmp++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin nBad++; $display("FAIL wrap_zero got addr=%h req=%0b want 0/1", imem_addr, imem_req); end
  endtask

  task automatic test_reset_mid_req();
    imem_ack = 1'b1;
    imem_rdata = NOP_WORD;
    step();
    imem_ack = 1'b0;
    step();
    nCmp++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin nBad++; $display("FAIL pre_rst got addr=%h req=%0b want 4/1", imem_addr, imem_req); end
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    reset = 1'b0;
    imem_ack = 1'b0;
    nCmp++; if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0) begin nBad++; $display("FAIL rst_ack got instr=%h valid=%0b req=%0b pc=%h want 0/0/0/0", instr, instr_valid, imem_req, pc); end
    step();
    nCmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin nBad++; $display("FAIL rst_refetch got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_misalign();
    imem_ack = 1'b1;
    imem_rdata = NOP_WORD;
    step();
    imem_ack = 1'b0;
    branch_taken = 1'b1;
    branch_offset = 32'h6;
    step();
    branch_taken = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    nCmp++; if (err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin nBad++; $display("FAIL mis_err got err=%0b req=%0b valid=%0b want 1/0/0", err, imem_req, instr_valid); end
    imem_ack = 1'b1;
    step();
    step();
    imem_ack = 1'b0;
    nCmp++; if (err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin nBad++; $display("FAIL mis_hold got err=%0b req=%0b valid=%0b want 1/0/0", err, imem_req, instr_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    nCmp++; if (err !== 1'b0) begin nBad++; $display("FAIL mis_clear got err=%0b want 0", err); end
`else
    nCmp++; if (imem_addr !== 32'h4 || imem_req !== 1'b1 || err !== 1'b0) begin nBad++; $display("FAIL mis_force got addr=%h req=%0b err=%0b want 4/1/0", imem_addr, imem_req, err); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_wrap();
    test_reset_mid_req();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
